// File: rtl/instr_fetch_buf_if.sv
// Handshake bundle between the instruction writer / CPU fetch stage and the fetch buffer.
// The ovf flag exists only when INSTR_FETCH_BUF_OVF_EN is defined.
interface instr_fetch_buf_if #(
  parameter int AW = 3
);
  logic          instr_we;
  logic [7:0]    data_in;
  logic          flush;
  logic          fetch_rdy;
  logic          instr_valid;
  logic [7:0]    instr_out;
  logic          full;
  logic [AW:0]   count;
`ifdef INSTR_FETCH_BUF_OVF_EN
  logic          ovf;
`endif

  modport master (
    output instr_we, data_in, flush, fetch_rdy,
`ifdef INSTR_FETCH_BUF_OVF_EN
    input  ovf,
`endif
    input  instr_valid, instr_out, full, count
  );

  modport slave (
    input  instr_we, data_in, flush, fetch_rdy,
`ifdef INSTR_FETCH_BUF_OVF_EN
    output ovf,
`endif
    output instr_valid, instr_out, full, count
  );
endinterface

// File: rtl/instr_fetch_buf.sv
// Show-ahead circular byte FIFO between the instruction writer and the CPU fetch stage.
// Optional sticky overflow flag enabled by defining INSTR_FETCH_BUF_OVF_EN.
module instr_fetch_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_buf_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          valid;
  logic          is_full;
  logic          pop;
  logic          push;

  assign valid   = (cnt != '0);
  assign is_full = (cnt == FULL_CNT);
  assign pop     = valid && bus.fetch_rdy;
  // A pop frees the slot the same cycle, so a write at full is still accepted.
  assign push    = bus.instr_we && (!is_full || pop);

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

  // Storage is data only: no reset, writes simply suppressed when control discards them.
  always_ff @(posedge clk) begin
    if (push && !bus.flush && !rst)
      mem[wp] <= bus.data_in;
  end

`ifdef INSTR_FETCH_BUF_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst || bus.flush)
      ovf_q <= 1'b0;
    else if (bus.instr_we && is_full && !pop)
      ovf_q <= 1'b1;
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.instr_valid = valid;
  assign bus.full        = is_full;
  assign bus.count       = cnt;
  assign bus.instr_out   = valid ? mem[rp] : 8'h00;

endmodule

// File: tb/tb_instr_fetch_buf.sv
// Self-checking bench for instr_fetch_buf: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_instr_fetch_buf;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst;
  int   ntests = 0;
  int   nfail  = 0;

  byte unsigned q[$];
  bit           movf;

  instr_fetch_buf_if #(.AW(AW)) bus ();

  instr_fetch_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       we;
    logic [7:0] d;
    logic       fl;
    logic       rdy;
    int         ecnt;
    logic       evld;
    logic [7:0] eout;
    logic       efull;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, int'(bus.count), q.size());
    check({tag, ".valid"}, int'(bus.instr_valid), int'(q.size() != 0));
    check({tag, ".full"},  int'(bus.full), int'(q.size() == DEPTH));
    check({tag, ".out"},   int'(bus.instr_out), (q.size() != 0) ? int'(q[0]) : 0);
`ifdef INSTR_FETCH_BUF_OVF_EN
    check({tag, ".ovf"},   int'(bus.ovf), int'(movf));
`endif
  endtask

  // Drive one cycle of inputs, advance the reference model, then sample after the edge.
  task automatic apply(input logic r, input logic we, input logic [7:0] d,
                       input logic fl, input logic rdy, input bit do_check, input string tag);
    int sz;
    bit pop;
    bit push;
    rst = r;
    bus.instr_we = we;
    bus.data_in = d;
    bus.flush = fl;
    bus.fetch_rdy = rdy;
    sz = q.size();
    pop = (sz != 0) && rdy;
    push = we && ((sz < DEPTH) || pop);
    if (r || fl) begin
      q.delete();
      movf = 1'b0;
    end else begin
      if (we && sz == DEPTH && !pop) movf = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
    @(posedge clk);
    #1;
    if (do_check) check_model(tag);
  endtask

  vec_t tbl[$];
  int   last;

  initial begin
    rst = 1'b1;
    bus.instr_we = 1'b0;
    bus.data_in = 8'h00;
    bus.flush = 1'b0;
    bus.fetch_rdy = 1'b0;
    movf = 1'b0;

    // Basic ordering, empty-pop, push-into-empty and count=1 push+pop.
    tbl.push_back('{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 1, 8'hA1, 0, 0, 1, 1, 8'hA1, 0});
    tbl.push_back('{0, 1, 8'hB2, 0, 0, 2, 1, 8'hA1, 0});
    tbl.push_back('{0, 1, 8'hC3, 0, 0, 3, 1, 8'hA1, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 2, 1, 8'hB2, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 1, 8'hC3, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 1, 8'h11, 0, 1, 1, 1, 8'h11, 0});
    tbl.push_back('{0, 1, 8'h22, 0, 1, 1, 1, 8'h22, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0});

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].we, tbl[i].d, tbl[i].fl, tbl[i].rdy, 1'b0, "tbl");
      check($sformatf("tbl%0d.count", i), int'(bus.count), tbl[i].ecnt);
      check($sformatf("tbl%0d.valid", i), int'(bus.instr_valid), int'(tbl[i].evld));
      check($sformatf("tbl%0d.out", i), int'(bus.instr_out), int'(tbl[i].eout));
      check($sformatf("tbl%0d.full", i), int'(bus.full), int'(tbl[i].efull));
    end

    // Overflow: 9 writes into 8 entries, ninth dropped, drain yields 01..08.
    apply(1, 0, 8'h00, 0, 0, 1'b1, "ovf_rst");
    for (int i = 1; i <= 9; i++) begin
      apply(0, 1, 8'(i), 0, 0, 1'b1, "ovf_fill");
      if (i == 8) check("ovf_full_after8", int'(bus.full), 1);
    end
    check("ovf_count", int'(bus.count), 8);
`ifdef INSTR_FETCH_BUF_OVF_EN
    check("ovf_sticky", int'(bus.ovf), 1);
`endif
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovf_drain%0d", i), int'(bus.instr_out), i);
      apply(0, 0, 8'h00, 0, 1, 1'b1, "ovf_drain");
    end
    check("ovf_empty", int'(bus.instr_valid), 0);

    // Streaming at full across pointer wrap.
    apply(1, 0, 8'h00, 0, 0, 1'b1, "wrap_rst");
    for (int i = 0; i < 8; i++) apply(0, 1, 8'(i), 0, 0, 1'b1, "wrap_fill");
    last = -1;
    for (int i = 8; i < 28; i++) begin
      check("wrap_incr", int'(bus.instr_out), last + 1);
      last = int'(bus.instr_out);
      apply(0, 1, 8'(i), 0, 1, 1'b1, "wrap_stream");
      check("wrap_full", int'(bus.full), 1);
    end
`ifdef INSTR_FETCH_BUF_OVF_EN
    check("wrap_noovf", int'(bus.ovf), 0);
`endif

    // Flush beats a same-cycle push and pop.
    apply(1, 0, 8'h00, 0, 0, 1'b1, "fl_rst");
    for (int i = 0; i < 5; i++) apply(0, 1, 8'h40 + 8'(i), 0, 0, 1'b1, "fl_fill");
    apply(0, 1, 8'hEE, 1, 1, 1'b1, "fl_flush");
    check("fl_count0", int'(bus.count), 0);
    apply(0, 1, 8'h5A, 0, 0, 1'b1, "fl_push");
    check("fl_5a", int'(bus.instr_out), 8'h5A);

    // Reset mid-stream overrides a write.
    for (int i = 0; i < 3; i++) apply(0, 1, 8'h70 + 8'(i), 0, 0, 1'b1, "rs_fill");
    check("rs_count4", int'(bus.count), 4);
    apply(1, 1, 8'h99, 0, 0, 1'b1, "rs_rst");
    check("rs_out0", int'(bus.instr_out), 0);
    apply(0, 1, 8'h33, 0, 0, 1'b1, "rs_push");
    check("rs_33", int'(bus.instr_out), 8'h33);

    // Randomized traffic, with bursty write/read biases.
    for (int i = 0; i < 600; i++) begin
      logic r, we, fl, rdy;
      int bias;
      bias = (i / 50) % 3;
      r   = ($urandom_range(0, 99) == 0);
      fl  = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 5)));
      rdy = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 8 : 5)));
      apply(r, we, 8'($urandom), fl, rdy, 1'b1, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
